ram_fifo_ctrl: RTL and testbench

FIFO controller that turns the single-port block RAM (`ram_singleport`) into a first-in/first-out byte buffer between the USB receive path and the 3-wire serial transmit path. It owns the write and read pointers and arbitrates the single RAM port between pushes and reads. It drives the RAM's address, data and write-enable inputs, and captures the RAM's registered read data into an output holding register with a valid/ready pop interface.

---
 rtl/ram_fifo_ctrl.sv | 116 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: byte FIFO over a single-port, registered-read block RAM.
// One RAM access per cycle, shared between pushes and reads, with a pop-side hold register.
module ram_fifo_ctrl #(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_DATA_WIDTH = 8
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic                      in_push_valid,
    input  logic [RAM_DATA_WIDTH-1:0] in_push_data,
    output logic                      out_push_ready,
    output logic                      out_pop_valid,
    output logic [RAM_DATA_WIDTH-1:0] out_pop_data,
    input  logic                      in_pop_ready,
    output logic [RAM_ADDR_WIDTH-1:0] out_ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] out_ram_data,
    output logic                      out_ram_wr,
    input  logic [RAM_DATA_WIDTH-1:0] in_ram_data,
    output logic [RAM_ADDR_WIDTH:0]   out_count,
    output logic                      out_full,
    output logic                      out_empty
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [RAM_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [RAM_ADDR_WIDTH:0]   count_q, count_d;
    logic                      prio_q, prio_d;
    logic [RAM_DATA_WIDTH-1:0] data_q, data_d;

    logic full;
    logic has_data;
    logic rd_gnt;
    logic wr_gnt;
    logic contested;

    // count never exceeds the depth, so its MSB alone marks full
    assign full      = count_q[RAM_ADDR_WIDTH];
    assign has_data  = (count_q != '0);
    assign rd_gnt    = (state_q == S_IDLE) && has_data
                     && (!in_push_valid || full || prio_q);
    assign wr_gnt    = in_push_valid && !full && !rd_gnt;
    assign contested = (state_q == S_IDLE) && has_data
                     && in_push_valid && !full;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        prio_d   = prio_q;
        data_d   = data_q;

        if (wr_gnt) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end
        if (rd_gnt) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
        if (contested) begin
            prio_d = !prio_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rd_gnt) state_d = S_RD;
            end
            S_RD: begin
                // capture precedes any write-through at this same edge
                state_d = S_HOLD;
                data_d  = in_ram_data;
            end
            S_HOLD: begin
                if (in_pop_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            prio_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            prio_q   <= prio_d;
            data_q   <= data_d;
        end
    end

    assign out_push_ready = !full && !rd_gnt;
    assign out_pop_valid  = (state_q == S_HOLD);
    assign out_pop_data   = data_q;
    assign out_ram_wr     = wr_gnt;
    assign out_ram_addr   = wr_gnt ? wr_ptr_q : rd_ptr_q;
    assign out_ram_data   = in_push_data;
    assign out_count      = count_q;
    assign out_full       = full;
    assign out_empty      = !has_data && (state_q == S_IDLE);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: scoreboard bench for ram_fifo_ctrl with a behavioural
// single-port RAM (registered read, write-through on write).
module tb_ram_fifo_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push_valid = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          push_ready;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic          pop_ready = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wr;
    logic [DW-1:0] ram_rdata = '0;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb[$];
    logic [DW-1:0] mem [2**AW];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr] <= ram_wdata;
            ram_rdata     <= ram_wdata;
        end else begin
            ram_rdata <= mem[ram_addr];
        end
    end

    ram_fifo_ctrl #(
        .RAM_ADDR_WIDTH(AW),
        .RAM_DATA_WIDTH(DW)
    ) dut (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_push_valid (push_valid),
        .in_push_data  (push_data),
        .out_push_ready(push_ready),
        .out_pop_valid (pop_valid),
        .out_pop_data  (pop_data),
        .in_pop_ready  (pop_ready),
        .out_ram_addr  (ram_addr),
        .out_ram_data  (ram_wdata),
        .out_ram_wr    (ram_wr),
        .in_ram_data   (ram_rdata),
        .out_count     (count),
        .out_full      (full),
        .out_empty     (empty)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        logic [DW-1:0] expd;
        apply_reset();
        push_valid = 1'b1;
        push_data  = 8'h3C;
        next_cycle();
        push_valid = 1'b0;
        repeat (4) next_cycle();
        checks++;
        if (pop_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_hold: got %b, required 1", pop_valid);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (pop_valid !== 1'b0 || pop_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_pop: got v=%b d=%h, required v=0 d=00", pop_valid, pop_data);
        end
        checks++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got cnt=%0d e=%b f=%b, required 0 1 0", count, empty, full);
        end
        checks++;
        if (push_ready !== 1'b1 || ram_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_port: got rdy=%b wr=%b, required 1 0", push_ready, ram_wr);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        expd = 8'h00;
        checks++;
        if (ram_addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h, required %h", ram_addr, expd);
        end
    endtask

    task automatic test_single_word();
        logic [DW-1:0] expd;
        apply_reset();
        pop_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push_valid = (k == 0);
            push_data  = 8'hA5;
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (ram_wr !== 1'b1 || ram_addr !== '0 || push_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL single_write: got wr=%b a=%h, required wr=1 a=0", ram_wr, ram_addr);
                end
            end
            if (k == 1) begin
                checks++;
                if (ram_wr !== 1'b0 || ram_addr !== '0 || count !== 5'd1) begin
                    errors++;
                    $display("FAIL single_read: got wr=%b a=%h cnt=%0d, required 0 0 1", ram_wr, ram_addr, count);
                end
            end
            if (push_valid && push_ready) sb.push_back(push_data);
            checks++;
            if (pop_valid !== (k == 3)) begin
                errors++;
                $display("FAIL single_valid_c%0d: got %b, required %b", k, pop_valid, (k == 3));
            end
            if (pop_valid && pop_ready && sb.size() != 0) begin
                expd = sb.pop_front();
                checks++;
                if (pop_data !== expd) begin
                    errors++;
                    $display("FAIL single_data: got %h, required %h", pop_data, expd);
                end
            end
            next_cycle();
        end
        checks++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL single_empty: got e=%b left=%0d, required 1 0", empty, sb.size());
        end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] expd;
        int            n;
        apply_reset();
        push_valid = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && !full; k++) begin
            push_data = n[DW-1:0];
            @(negedge clk);
            if (push_valid && push_ready) begin
                sb.push_back(push_data);
                n++;
            end
            next_cycle();
        end
        checks++;
        if (n != 17 || full !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL fill_full: got n=%0d f=%b cnt=%0d, required 17 1 16", n, full, count);
        end
        push_data = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (push_ready !== 1'b0 || ram_wr !== 1'b0) begin
                errors++;
                $display("FAIL full_block: got rdy=%b wr=%b, required 0 0", push_ready, ram_wr);
            end
            next_cycle();
        end
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        for (int k = 0; k < 200 && sb.size() != 0; k++) begin
            @(negedge clk);
            if (pop_valid && pop_ready) begin
                expd = sb.pop_front();
                checks++;
                if (pop_data !== expd) begin
                    errors++;
                    $display("FAIL drain_data: got %h, required %h", pop_data, expd);
                end
            end
            next_cycle();
        end
        checks++;
        if (sb.size() != 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_done: got left=%0d e=%b, required 0 1", sb.size(), empty);
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] expd;
        logic          want;
        int            n;
        apply_reset();
        pop_ready  = 1'b1;
        push_valid = 1'b1;
        n = 0;
        // contested cycles 1,2,5,6,9,10 must go W,R,W,R,...
        for (int k = 0; k < 12; k++) begin
            push_data = 8'h40 + n[DW-1:0];
            want = (k < 2) || (((k - 2) % 4) != 0);
            @(negedge clk);
            checks++;
            if (push_ready !== want || ram_wr !== want) begin
                errors++;
                $display("FAIL contend_c%0d: got rdy=%b wr=%b, required %b", k, push_ready, ram_wr, want);
            end
            if (push_valid && push_ready) begin
                sb.push_back(push_data);
                n++;
            end
            if (pop_valid && pop_ready) begin
                expd = sb.pop_front();
                checks++;
                if (pop_data !== expd) begin
                    errors++;
                    $display("FAIL contend_data: got %h, required %h", pop_data, expd);
                end
            end
            next_cycle();
        end
        push_valid = 1'b0;
        for (int k = 0; k < 200 && sb.size() != 0; k++) begin
            @(negedge clk);
            if (pop_valid && pop_ready) begin
                expd = sb.pop_front();
                checks++;
                if (pop_data !== expd) begin
                    errors++;
                    $display("FAIL contend_drain: got %h, required %h", pop_data, expd);
                end
            end
            next_cycle();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL contend_timeout: got left=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] expd;
        int            sent;
        int            got;
        apply_reset();
        sent = 0;
        got  = 0;
        for (int k = 0; k < 6000 && got < 300; k++) begin
            push_valid = (sent < 300) && ($urandom_range(0, 1) == 1);
            push_data  = sent[DW-1:0];
            pop_ready  = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (push_valid && push_ready) begin
                sb.push_back(push_data);
                sent++;
            end
            if (pop_valid && pop_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_extra: got %h, required no word", pop_data);
                end else begin
                    expd = sb.pop_front();
                    if (pop_data !== expd) begin
                        errors++;
                        $display("FAIL wrap_data: got %h, required %h", pop_data, expd);
                    end
                end
                got++;
            end
            next_cycle();
        end
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        checks++;
        if (got != 300 || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_count: got %0d e=%b, required 300 1", got, empty);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] expd;
        apply_reset();
        push_valid = 1'b1;
        push_data  = 8'h11;
        next_cycle();
        push_valid = 1'b0;
        next_cycle();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pop_valid !== 1'b0 || count !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL midrd_reset: got v=%b cnt=%0d e=%b, required 0 0 1", pop_valid, count, empty);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (pop_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrd_quiet: got %b, required 0", pop_valid);
            end
            next_cycle();
        end
        push_valid = 1'b1;
        push_data  = 8'h22;
        @(negedge clk);
        checks++;
        if (ram_wr !== 1'b1 || ram_addr !== '0) begin
            errors++;
            $display("FAIL midrd_waddr: got wr=%b a=%h, required 1 0", ram_wr, ram_addr);
        end
        if (push_valid && push_ready) sb.push_back(push_data);
        next_cycle();
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_wr !== 1'b0 || ram_addr !== '0) begin
            errors++;
            $display("FAIL midrd_raddr: got wr=%b a=%h, required 0 0", ram_wr, ram_addr);
        end
        next_cycle();
        for (int k = 0; k < 10 && sb.size() != 0; k++) begin
            @(negedge clk);
            if (pop_valid && pop_ready) begin
                expd = sb.pop_front();
                checks++;
                if (pop_data !== expd) begin
                    errors++;
                    $display("FAIL midrd_data: got %h, required %h", pop_data, expd);
                end
            end
            next_cycle();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL midrd_timeout: got left=%0d, required 0", sb.size());
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_word();
        test_fill_drain();
        test_contention();
        test_wrap();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
